// File: rtl/wb_dual_regfile.sv
// Dual-lane writeback stage and 32-entry architectural register file with
// four combinational read ports, same-cycle write bypass and a retire counter.
module wb_dual_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] readdata_1,
  input  logic [XLEN-1:0] readdata_2,
  input  logic [XLEN-1:0] resultalu_1,
  input  logic [XLEN-1:0] resultalu_2,
  input  logic [4:0]      rd_1,
  input  logic [4:0]      rd_2,
  input  logic            memtoreg_1,
  input  logic            memtoreg_2,
  input  logic            regwrite_1,
  input  logic            regwrite_2,
  input  logic [4:0]      rs1_a,
  input  logic [4:0]      rs2_a,
  input  logic [4:0]      rs1_b,
  input  logic [4:0]      rs2_b,
  output logic [XLEN-1:0] rdata1_a,
  output logic [XLEN-1:0] rdata2_a,
  output logic [XLEN-1:0] rdata1_b,
  output logic [XLEN-1:0] rdata2_b,
  output logic [XLEN-1:0] wb_data_1,
  output logic [XLEN-1:0] wb_data_2,
  output logic            wb_valid_1,
  output logic            wb_valid_2,
  output logic [31:0]     retire_count
);

  logic [XLEN-1:0] regs [NREG];
  logic [4:0]      raddr [4];
  logic [XLEN-1:0] rdata [4];

  assign wb_data_1  = memtoreg_1 ? readdata_1 : resultalu_1;
  assign wb_data_2  = memtoreg_2 ? readdata_2 : resultalu_2;
  assign wb_valid_1 = regwrite_1 && (rd_1 != 5'd0) && !reset;
  assign wb_valid_2 = regwrite_2 && (rd_2 != 5'd0) && !reset;

  // Lane 2 is younger, so its write is issued last and wins on a same-rd collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (wb_valid_1) regs[rd_1] <= wb_data_1;
      if (wb_valid_2) regs[rd_2] <= wb_data_2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) retire_count <= '0;
    else       retire_count <= retire_count + 32'(wb_valid_1) + 32'(wb_valid_2);
  end

  assign raddr[0] = rs1_a;
  assign raddr[1] = rs2_a;
  assign raddr[2] = rs1_b;
  assign raddr[3] = rs2_b;

  // Later assignments take priority: x0/reset over lane 2 over lane 1 over array.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[i] = regs[raddr[i]];
      if (wb_valid_1 && rd_1 == raddr[i]) rdata[i] = wb_data_1;
      if (wb_valid_2 && rd_2 == raddr[i]) rdata[i] = wb_data_2;
      if (reset || raddr[i] == 5'd0)      rdata[i] = '0;
    end
  end

  assign rdata1_a = rdata[0];
  assign rdata2_a = rdata[1];
  assign rdata1_b = rdata[2];
  assign rdata2_b = rdata[3];

endmodule

// File: doc/wb_dual_regfile.md
# wb_dual_regfile

Dual-issue writeback stage and architectural register file, sitting at the consumer end of the MEM/WB pipeline register. Each cycle it takes the two registered writeback lanes and selects load data or ALU result per lane. It commits up to two register writes and serves four read ports to the decode stage, with same-cycle write-to-read bypass. It also keeps a retired-writeback counter for performance monitoring.

## Interface
Parameters:
- XLEN, 32, data width of registers and writeback values
- NREG, 32, number of architectural registers; register 0 hardwired to zero; address width log2(NREG)=5

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- readdata_1 / readdata_2  in  XLEN  load data, lane 1 / lane 2
- resultalu_1 / resultalu_2  in  XLEN  ALU result, lane 1 / lane 2
- rd_1 / rd_2  in  5  destination register, lane 1 / lane 2
- memtoreg_1 / memtoreg_2  in  1  1 = write load data, 0 = write ALU result
- regwrite_1 / regwrite_2  in  1  lane write enable
- rs1_a, rs2_a, rs1_b, rs2_b  in  5  read addresses (a = decode slot 1, b = decode slot 2)
- rdata1_a, rdata2_a, rdata1_b, rdata2_b  out  XLEN  read data, combinational
- wb_data_1 / wb_data_2  out  XLEN  selected writeback value per lane, combinational (forwarding source for EX)
- wb_valid_1 / wb_valid_2  out  1  lane performs an effective write this cycle (regwrite and rd != 0 and not reset)
- retire_count  out  32  registered count of effective writes since reset

## Operation
- wb_data_n = memtoreg_n ? readdata_n : resultalu_n; always driven, independent of regwrite_n.
- Effective write, lane n: regwrite_n=1, rd_n!=0, reset=0. Writes with rd=0 are discarded; register 0 always reads 0.
- Both lanes writing the same rd: lane 2 is program-order younger and wins. The register gets wb_data_2 and lane 1's write is dropped.
- Read port (any of the four), in priority order:
  - addr=0 -> 0
  - reset=1 -> 0
  - lane 2 effectively writing addr -> wb_data_2
  - lane 1 effectively writing addr -> wb_data_1
  - else the array contents
- No read-port-to-read-port interaction. All four ports are independent and may alias freely.
- retire_count += wb_valid_1 + wb_valid_2 each cycle (0, 1 or 2). A same-rd collision still counts 2, since both instructions retired. The counter wraps modulo 2^32 with no saturation or flag.
- No stall or handshake. Every cycle's lanes are consumed unconditionally; bubbles arrive as regwrite=0.

## Timing
- Reset (sampled at rising edge with reset=1):
  - all NREG registers cleared to 0 in that single cycle
  - retire_count cleared to 0
  - lane writes in the same cycle are ignored
- While reset is high:
  - all rdata outputs = 0
  - wb_valid_1 = wb_valid_2 = 0
  - wb_data_n still follows its mux
- Reset mid-operation: pending lane writes in the reset cycle are lost. The first cycle after reset deasserts behaves normally.
- Write latency: a value is visible on a read port in the same cycle through bypass, and from the array from the next cycle on.
- retire_count reflects writes up to and including the previous edge. It is one cycle behind wb_valid.
- Read path is purely combinational: bypass compare, mux, array read. No internal registers on read data.

## Test plan
- Reset then read: reset held 1 cycle; all four read ports sweep addresses 0–31 -> every rdata = 0, retire_count = 0.
- Basic dual write: lane 1 writes rd=5 with ALU result 0x1111_1111; lane 2 writes rd=6 with memtoreg=1 and readdata 0xDEAD_BEEF -> next cycle rs1_a=5 reads 0x1111_1111, rs2_b=6 reads 0xDEAD_BEEF, retire_count = 2.
- Bypass and collision: in one cycle both lanes write rd=7 (lane 1: 0xAAAA_0001, lane 2: 0xBBBB_0002) while rs1_a=7 -> rdata1_a = 0xBBBB_0002 in the same cycle and afterwards; retire_count increments by 2.
- x0 protection: regwrite_1=1 with rd_1=0 and value 0xFFFF_FFFF -> reading address 0 returns 0 in the same and next cycle; wb_valid_1 = 0; retire_count unchanged.
- Counter wrap: force retire_count to 0xFFFF_FFFF (or run to it), then one dual write -> retire_count = 0x0000_0001.
- Reset mid-stream: write rd=3=0x1234, then assert reset in the same cycle as a lane-1 write rd=4=0x5678 -> after reset, rd 3 and rd 4 both read 0 and retire_count = 0.
